// File: rtl/mem_arbiter_if.sv
// Bundle of every non-clock/reset signal of the unified 8-bit memory arbiter:
// the IF and LS requester handshakes, the IO back-pressure flag and the
// byte-wide RAM/IO port.
interface mem_arbiter_if;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        flush;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  // Arbiter side: owns the memory port and the done/data returns.
  modport master (
    input  rdy, if_req, if_addr, flush, ls_req, ls_wr, ls_size, ls_addr,
           ls_wdata, io_buffer_full, mem_din,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  // Requesters plus memory side.
  modport slave (
    output rdy, if_req, if_addr, flush, ls_req, ls_wr, ls_size, ls_addr,
           ls_wdata, io_buffer_full, mem_din,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Sole owner of the 8-bit unified RAM/IO port. Shares it between the
// instruction-fetch unit and the load/store unit, walking multi-byte
// transfers one byte per cycle and packing/unpacking little-endian words.
// A read byte returns on mem_din one cycle after its address, so reads
// finish two edges after the last address; writes finish one edge after.
module mem_arbiter #(
  parameter logic [31:0] IO_BASE = 32'h00030000
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IF_RD = 2'd1;
  localparam logic [1:0] S_LS_RD = 2'd2;
  localparam logic [1:0] S_LS_WR = 2'd3;

  // Replace byte idx of a word.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (idx)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      default: w[31:24] = b;
    endcase
    return w;
  endfunction

  // Extract byte idx of a word.
  function automatic logic [7:0] get_byte(input logic [31:0] word,
                                          input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // Transfer length in bytes; the illegal size 3 is handled as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  logic [1:0]  state_r;
  logic [2:0]  cnt_r;      // edges taken since the grant edge
  logic [2:0]  nbytes_r;
  logic [31:0] base_r;
  logic [31:0] wdata_r;
  logic [31:0] mem_a_r;
  logic [7:0]  mem_dout_r;
  logic        wr_r;
  logic        if_done_r;
  logic        ls_done_r;
  logic [31:0] if_data_r;
  logic [31:0] ls_rdata_r;

  logic        io_stall_s;
  logic [31:0] addr_next_s;
  logic [1:0]  cap_idx_s;
  logic [31:0] rd_word_s;
  logic        last_rd_s;

  // IO write blocked this cycle; the byte being offered is held, not lost.
  assign io_stall_s  = (state_r == S_LS_WR) && (mem_a_r >= IO_BASE) && bus.io_buffer_full;
  assign addr_next_s = base_r + {29'd0, cnt_r};
  // At edge E_c the byte addressed two edges earlier (c-2) is on mem_din.
  assign cap_idx_s   = cnt_r[1:0] - 2'd2;
  assign rd_word_s   = put_byte((state_r == S_IF_RD) ? if_data_r : ls_rdata_r,
                                cap_idx_s, bus.mem_din);
  assign last_rd_s   = (cnt_r == (nbytes_r + 3'd1));

  assign bus.mem_a    = mem_a_r;
  assign bus.mem_dout = mem_dout_r;
  assign bus.mem_wr   = wr_r & bus.rdy & ~io_stall_s;
  assign bus.if_done  = if_done_r;
  assign bus.if_data  = if_data_r;
  assign bus.ls_done  = ls_done_r;
  assign bus.ls_rdata = ls_rdata_r;

  // Grant, byte sequencing, data assembly and done pulses; rdy low freezes all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= 3'd0;
      nbytes_r   <= 3'd0;
      base_r     <= 32'd0;
      wdata_r    <= 32'd0;
      mem_a_r    <= 32'd0;
      mem_dout_r <= 8'd0;
      wr_r       <= 1'b0;
      if_done_r  <= 1'b0;
      ls_done_r  <= 1'b0;
      if_data_r  <= 32'd0;
      ls_rdata_r <= 32'd0;
    end else if (bus.rdy) begin
      if_done_r <= 1'b0;
      ls_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // Holding off while a done is visible lets the requester drop req.
          if (!if_done_r && !ls_done_r) begin
            if (bus.ls_req) begin
              base_r   <= bus.ls_addr;
              wdata_r  <= bus.ls_wdata;
              nbytes_r <= size_bytes(bus.ls_size);
              mem_a_r  <= bus.ls_addr;
              cnt_r    <= 3'd1;
              if (bus.ls_wr) begin
                mem_dout_r <= bus.ls_wdata[7:0];
                wr_r       <= 1'b1;
                state_r    <= S_LS_WR;
              end else begin
                ls_rdata_r <= 32'd0;
                state_r    <= S_LS_RD;
              end
            end else if (bus.if_req && !bus.flush) begin
              base_r    <= bus.if_addr;
              nbytes_r  <= 3'd4;
              mem_a_r   <= bus.if_addr;
              cnt_r     <= 3'd1;
              if_data_r <= 32'd0;
              state_r   <= S_IF_RD;
            end else begin
              state_r <= S_IDLE;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_IF_RD, S_LS_RD: begin
          if ((state_r == S_IF_RD) && bus.flush) begin
            // Redirect wins even over a completing fetch: no if_done.
            state_r <= S_IDLE;
            mem_a_r <= 32'd0;
            cnt_r   <= 3'd0;
          end else begin
            if (cnt_r < nbytes_r) begin
              mem_a_r <= addr_next_s;
            end else begin
              mem_a_r <= mem_a_r;
            end
            if (cnt_r >= 3'd2) begin
              if (state_r == S_IF_RD) begin
                if_data_r <= rd_word_s;
              end else begin
                ls_rdata_r <= rd_word_s;
              end
            end else begin
              cnt_r <= cnt_r;
            end
            if (last_rd_s) begin
              if (state_r == S_IF_RD) begin
                if_done_r <= 1'b1;
              end else begin
                ls_done_r <= 1'b1;
              end
              state_r <= S_IDLE;
              cnt_r   <= 3'd0;
            end else begin
              cnt_r <= cnt_r + 3'd1;
            end
          end
        end
        S_LS_WR: begin
          if (!io_stall_s) begin
            if (cnt_r == nbytes_r) begin
              wr_r      <= 1'b0;
              ls_done_r <= 1'b1;
              state_r   <= S_IDLE;
              cnt_r     <= 3'd0;
            end else begin
              mem_a_r    <= addr_next_s;
              mem_dout_r <= get_byte(wdata_r, cnt_r[1:0]);
              cnt_r      <= cnt_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter. A byte-addressable device
// RAM answers the port one cycle after each address; an independent
// reference memory predicts load results, write beats and latencies.
module tb_mem_arbiter;
  localparam logic [31:0] IO_BASE = 32'h00030000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   bad_wr;

  logic [7:0]  ram     [logic [31:0]];  // device contents, written by DUT
  logic [7:0]  ref_mem [logic [31:0]];  // expected contents
  logic [63:0] wr_log  [$];             // {addr, 24'0, byte} per mem_wr cycle
  logic [31:0] atrace  [$];             // mem_a per cycle of a transaction

  mem_arbiter_if bus();
  mem_arbiter #(.IO_BASE(IO_BASE)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = ref_rd(a + 32'(k));
    return w;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample the port, let the edge pass, then answer as the RAM.
  task automatic step();
    logic [31:0] a;
    logic [7:0]  o;
    logic [7:0]  d;
    logic        w;
    #1;
    a = bus.mem_a;
    o = bus.mem_dout;
    w = bus.mem_wr;
    d = ram_rd(a);
    if (w && (!bus.rdy || (bus.io_buffer_full && a >= IO_BASE))) bad_wr++;
    @(posedge clk);
    #1;
    bus.mem_din = d;
    if (w) begin
      ram[a] = o;
      wr_log.push_back({a, 24'd0, o});
    end
  endtask

  // Run one IF read or LS transaction with optional rdy / io_buffer_full windows.
  task automatic run_txn(input bit is_if, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int rdy_at, input int rdy_len,
                         input int full_at, input int full_len,
                         output logic [31:0] data);
    int   n, lat, exp_lat;
    logic done;
    n = is_if ? 4 : nbytes(size);
    wr_log.delete();
    atrace.delete();
    bad_wr = 0;
    if (is_if) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.ls_req = 1'b1; bus.ls_wr = wr; bus.ls_size = size;
      bus.ls_addr = addr; bus.ls_wdata = wdata;
    end
    lat = 0;
    done = 1'b0;
    while (!done && lat < 60) begin
      bus.rdy = !(lat >= rdy_at && lat < rdy_at + rdy_len);
      bus.io_buffer_full = (lat >= full_at && lat < full_at + full_len);
      step();
      lat++;
      atrace.push_back(bus.mem_a);
      done = is_if ? bus.if_done : bus.ls_done;
    end
    bus.rdy = 1'b1; bus.io_buffer_full = 1'b0;
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    data = is_if ? bus.if_data : bus.ls_rdata;
    exp_lat = (wr ? n + 1 : n + 2) + rdy_len + ((wr && addr >= IO_BASE) ? full_len : 0);
    check("txn_latency", 32'(lat), 32'(exp_lat));
    if (!wr) begin
      check("load_data", data, ref_load(addr, n));
      if (rdy_len == 0)
        for (int k = 0; k < n && k < atrace.size(); k++)
          check("rd_addr_seq", atrace[k], addr + 32'(k));
    end else begin
      check("wr_count", 32'(wr_log.size()), 32'(n));
      for (int k = 0; k < n && k < wr_log.size(); k++) begin
        check("wr_beat_addr", wr_log[k][63:32], addr + 32'(k));
        check("wr_beat_data", wr_log[k][31:0], {24'd0, wdata[8*k +: 8]});
      end
      for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
      check("wr_stall_leak", 32'(bad_wr), 32'd0);
    end
    step();
    check("done_pulse_width", {30'd0, bus.if_done, bus.ls_done}, 32'd0);
  endtask

  initial begin
    logic [31:0] d, a, wd;
    logic [1:0]  sz;
    int          t, cnt_done, kind;

    bus.rdy = 1'b1; bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.flush = 1'b0;
    bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_size = 2'd0; bus.ls_addr = 32'd0;
    bus.ls_wdata = 32'd0; bus.io_buffer_full = 1'b0; bus.mem_din = 8'd0;
    rst = 1'b1;
    repeat (3) step();
    check("rst_ctrl", {29'd0, bus.if_done, bus.ls_done, bus.mem_wr}, 32'd0);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    check("rst_if_data", bus.if_data, 32'd0);
    check("rst_ls_rdata", bus.ls_rdata, 32'd0);
    rst = 1'b0;

    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'hA0); poke(32'h103, 8'h00);
    poke(32'h200, 8'hEF); poke(32'h201, 8'hBE); poke(32'h202, 8'hAD); poke(32'h203, 8'hDE);
    poke(32'h301, 8'h34); poke(32'h302, 8'h12);
    poke(32'h0, 8'h11); poke(32'h1, 8'h22); poke(32'h2, 8'h33); poke(32'h3, 8'h44);
    poke(32'hFFFFFFFE, 8'h5A); poke(32'hFFFFFFFF, 8'hC3);
    for (int i = 0; i < 4; i++) poke(32'h80 + 32'(i), 8'($urandom()));
    for (int i = 0; i < 4; i++) poke(IO_BASE + 32'h10 + 32'(i), 8'($urandom()));
    for (int i = 0; i < 272; i++) poke(32'h400 + 32'(i), 8'($urandom()));

    // Instruction fetch of a known word.
    run_txn(1'b1, 1'b0, 2'd2, 32'h100, 32'd0, 0, 0, 0, 0, d);
    check("if_word_0x100", d, 32'h00A00513);

    // Half load from an odd address.
    run_txn(1'b0, 1'b0, 2'd1, 32'h301, 32'd0, 0, 0, 0, 0, d);
    check("ls_half_0x301", d, 32'h00001234);

    // Byte store to IO with the write buffer full for three cycles.
    run_txn(1'b0, 1'b1, 2'd0, IO_BASE, 32'h00000041, 0, 0, 1, 3, d);

    // IO loads ignore io_buffer_full; illegal size 3 behaves as word.
    run_txn(1'b0, 1'b0, 2'd2, IO_BASE + 32'h10, 32'd0, 0, 0, 1, 3, d);
    run_txn(1'b0, 1'b0, 2'd3, 32'h200, 32'd0, 0, 0, 0, 0, d);
    check("ls_size3_word", d, 32'hDEADBEEF);

    // Word store with rdy low for three cycles mid-transfer.
    run_txn(1'b0, 1'b1, 2'd2, 32'h10, 32'hCAFEF00D, 2, 3, 0, 0, d);
    check("st_ram_0x10", {ram_rd(32'h13), ram_rd(32'h12), ram_rd(32'h11), ram_rd(32'h10)}, 32'hCAFEF00D);

    // Fetch across the top of the address space.
    run_txn(1'b1, 1'b0, 2'd2, 32'hFFFFFFFE, 32'd0, 0, 0, 0, 0, d);
    check("if_wrap", d, 32'h2211C35A);

    // Simultaneous requests: LS wins, one idle cycle, then IF.
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = 2'd2; bus.ls_addr = 32'h200;
    t = 0;
    while (!bus.ls_done && t < 40) begin step(); t++; end
    check("arb_ls_lat", 32'(t), 32'd6);
    check("arb_ls_data", bus.ls_rdata, 32'hDEADBEEF);
    check("arb_if_not_yet", {31'd0, bus.if_done}, 32'd0);
    bus.ls_req = 1'b0;
    while (!bus.if_done && t < 60) begin step(); t++; end
    check("arb_if_lat", 32'(t), 32'd13);
    check("arb_if_data", bus.if_data, ref_load(32'h0, 4));
    bus.if_req = 1'b0;
    step();

    // Flush two cycles into a fetch, then redirect to 0x80.
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    step(); step();
    bus.flush = 1'b1;
    step();
    check("flush_no_done", {31'd0, bus.if_done}, 32'd0);
    check("flush_mem_a", bus.mem_a, 32'd0);
    bus.flush = 1'b0; bus.if_addr = 32'h80;
    t = 0;
    while (!bus.if_done && t < 40) begin
      step(); t++;
      if (t == 1) check("flush_regrant_a", bus.mem_a, 32'h80);
    end
    check("flush_regrant_lat", 32'(t), 32'd6);
    check("flush_regrant_data", bus.if_data, ref_load(32'h80, 4));
    bus.if_req = 1'b0;
    step();

    // Reset mid-fetch abandons it silently.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; bus.if_req = 1'b0;
    cnt_done = 0;
    repeat (8) begin step(); if (bus.if_done) cnt_done++; end
    check("midrst_no_done", 32'(cnt_done), 32'd0);
    check("midrst_mem_a", bus.mem_a, 32'd0);

    // Randomized mix checked against the reference memory.
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      a    = 32'h400 + 32'($urandom_range(0, 255));
      wd   = $urandom();
      if (kind == 0)
        run_txn(1'b1, 1'b0, 2'd2, a, 32'd0, 1, $urandom_range(0, 2), 0, 0, d);
      else if (kind == 1)
        run_txn(1'b0, 1'b0, sz, a, 32'd0, 1, $urandom_range(0, 2), 0, 0, d);
      else if ($urandom_range(0, 1) == 1)
        run_txn(1'b0, 1'b1, sz, IO_BASE + 32'($urandom_range(0, 15)), wd, 0, 0, 1, $urandom_range(0, 3), d);
      else
        run_txn(1'b0, 1'b1, sz, a, wd, 1, $urandom_range(0, 2), 0, 0, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single owner of the 8-bit unified RAM/IO port; shares it between the instruction-fetch unit (IF) and the load/store unit (LS).
- Sequences multi-byte transfers byte by byte and assembles or splits little-endian words.
- Returns one-cycle done pulses to each requester.
- Honours fetch flush on control-flow redirect and IO back-pressure.

Parameters:
IO_BASE, 32'h00030000, addresses >= IO_BASE are IO; writes there obey io_buffer_full

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; low freezes block
if_req  in  1  IF wants a 4-byte instruction read
if_addr  in  32  fetch address
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
flush  in  1  redirect; abort/suppress pending IF read
ls_req  in  1  LS transaction request
ls_wr  in  1  1=store, 0=load
ls_size  in  2  0=byte, 1=half, 2=word (3 illegal, treat as word)
ls_addr  in  32  base address
ls_wdata  in  32  store data, byte k = bits [8k+7:8k]
ls_done  out  1  one-cycle pulse; load data valid / store complete
ls_rdata  out  32  load data, zero-extended
io_buffer_full  in  1  IO write buffer full
mem_din  in  8  RAM/IO read byte (valid the cycle after its address was driven)
mem_dout  out  8  write byte
mem_a  out  32  byte address
mem_wr  out  1  1=write

Behaviour:
- Reset: state IDLE, counters 0; if_done, ls_done, mem_wr = 0; mem_a, mem_dout, if_data, ls_rdata = 0. Reset mid-transfer abandons it with no done pulse.
- States: IDLE, IF_RD, LS_RD, LS_WR. All outputs registered except mem_wr gating by rdy.
- Grant, at a clock edge E0 in IDLE:
  - ls_req has priority over if_req.
  - IF is not granted if flush is high at that edge.
  - No grant at an edge where if_done or ls_done is currently high. This lets requesters drop req on seeing done.
- Requester rule: req, addr, size, wr and wdata stay stable from request until done is sampled.
- Byte count N: 4 for IF; 1/2/4 from ls_size.
- Read: byte k address (base+k) is driven on mem_a during the cycle after edge E_k, k=0..N-1.
  - Byte k is captured from mem_din at edge E_(k+2) into bits [8k+7:8k]; upper unread bytes = 0.
  - done is registered high at edge E_(N+1): visible one cycle; N+2 cycles from request edge to done cycle. State returns to IDLE.
- Write: during the cycle after edge E_k: mem_a = base+k, mem_dout = wdata byte k, mem_wr = 1.
  - ls_done is high in the cycle after E_N; mem_wr returns to 0 in that cycle.
- IO back-pressure: in LS_WR with address >= IO_BASE and io_buffer_full high, hold mem_a/mem_dout, drive mem_wr = 0, freeze the byte counter. Resume when it clears. Loads from IO are not stalled.
- Flush:
  - In IF_RD, flush high at an edge: go to IDLE, no if_done, mem_a = 0.
  - If that same edge would assert if_done, if_done is suppressed.
  - Flush never affects LS states.
- rdy low: all registers hold. mem_wr forced 0 combinationally; mem_a held, so the in-flight read byte stays valid on resume. done pulses extend across the stall.
- Address arithmetic is 32-bit, wraps modulo 2^32 (0xFFFFFFFF+1 = 0).

Test Plan:
- IF read, if_addr=0x100, RAM[0x100..0x103]=13,05,A0,00 → mem_a = 0x100..0x103 on consecutive cycles; if_done high exactly one cycle, 6 cycles after request edge, if_data=0x00A00513.
- Simultaneous if_req (0x0) and ls_req (load word 0x200=0xDEADBEEF) → ls_done first with ls_rdata=0xDEADBEEF; one idle cycle; then IF read of 0x0 completes.
- LS half load from 0x301, bytes 34,12 → ls_rdata=0x00001234, ls_done 4 cycles after request edge.
- Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles → mem_wr low for those 3 cycles, then one mem_wr=1 cycle with mem_dout=0x41, mem_a=0x30000; then ls_done.
- flush asserted 2 cycles into IF read of 0x40 → no if_done, mem_a=0 next cycle. A new if_req(0x80) is granted the edge after flush drops and completes normally.
- rdy low 3 cycles mid word store to 0x10 → no mem_wr during stall; exactly 4 write cycles total, each with correct byte/address; RAM matches ls_wdata.
